// File: rtl/vd_pkg.sv
// Shared trellis definitions for the 8-state survivor-memory decoder family.
// Holds state geometry, the default metric width and the trellis helper functions.
package vd_pkg;

    localparam int NUM_STATES = 8;
    localparam int STATE_W    = 3;
    localparam int PM_W_DEF   = 3;

    // Predecessor of ns along the branch chosen by its survivor decision bit.
    function automatic logic [STATE_W-1:0] pred_state(input logic [STATE_W-1:0] ns,
                                                      input logic d);
        return {ns[1:0], d};
    endfunction

    function automatic logic in_bit(input logic [STATE_W-1:0] ns);
        return ns[2];
    endfunction

endpackage

// File: rtl/pm_argmin8.sv
// Combinational argmin over eight unsigned path metrics; ties resolve to the lowest index.
// Kept standalone so a traceback decoder can share it.
module pm_argmin8
    import vd_pkg::*;
#(
    parameter int PM_W = PM_W_DEF
) (
    input  logic [PM_W-1:0]    pm0,
    input  logic [PM_W-1:0]    pm1,
    input  logic [PM_W-1:0]    pm2,
    input  logic [PM_W-1:0]    pm3,
    input  logic [PM_W-1:0]    pm4,
    input  logic [PM_W-1:0]    pm5,
    input  logic [PM_W-1:0]    pm6,
    input  logic [PM_W-1:0]    pm7,
    output logic [STATE_W-1:0] idx
);

    logic [PM_W-1:0] pm [NUM_STATES];
    logic [PM_W-1:0] best;

    assign pm[0] = pm0;
    assign pm[1] = pm1;
    assign pm[2] = pm2;
    assign pm[3] = pm3;
    assign pm[4] = pm4;
    assign pm[5] = pm5;
    assign pm[6] = pm6;
    assign pm[7] = pm7;

    // Strict less-than keeps the earlier index on equal metrics.
    always_comb begin
        idx  = '0;
        best = pm[0];
        for (int s = 1; s < NUM_STATES; s++) begin
            if (pm[s] < best) begin
                best = pm[s];
                idx  = STATE_W'(s);
            end
        end
    end

endmodule

// File: rtl/smu_regex.sv
// Register-exchange survivor memory for an 8-state Viterbi decoder.
// Each state carries its full survivor in flops; the oldest bit of the best state is emitted.
module smu_regex
    import vd_pkg::*;
#(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = PM_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [7:0]         dec,
    input  logic [PM_W-1:0]    pm0,
    input  logic [PM_W-1:0]    pm1,
    input  logic [PM_W-1:0]    pm2,
    input  logic [PM_W-1:0]    pm3,
    input  logic [PM_W-1:0]    pm4,
    input  logic [PM_W-1:0]    pm5,
    input  logic [PM_W-1:0]    pm6,
    input  logic [PM_W-1:0]    pm7,
    output logic               out_valid,
    output logic               out_bit,
    output logic [STATE_W-1:0] best_state
);

    localparam int CNT_W = $clog2(TB_DEPTH + 1);

    logic [TB_DEPTH-1:0] path     [NUM_STATES];
    logic [TB_DEPTH-1:0] path_nxt [NUM_STATES];
    logic [CNT_W-1:0]    fill;
    logic [CNT_W-1:0]    fill_nxt;
    logic [STATE_W-1:0]  best_nxt;

    pm_argmin8 #(.PM_W(PM_W)) u_argmin (
        .pm0 (pm0),
        .pm1 (pm1),
        .pm2 (pm2),
        .pm3 (pm3),
        .pm4 (pm4),
        .pm5 (pm5),
        .pm6 (pm6),
        .pm7 (pm7),
        .idx (best_nxt)
    );

    // All survivors are rebuilt from pre-update values, so the exchange is simultaneous.
    always_comb begin
        for (int ns = 0; ns < NUM_STATES; ns++) begin
            path_nxt[ns] = {path[pred_state(STATE_W'(ns), dec[ns])][TB_DEPTH-2:0],
                            in_bit(STATE_W'(ns))};
        end
        fill_nxt = (fill == CNT_W'(TB_DEPTH)) ? fill : fill + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NUM_STATES; s++) path[s] <= '0;
            fill       <= '0;
            best_state <= '0;
            out_valid  <= 1'b0;
            out_bit    <= 1'b0;
        end else if (clr) begin
            for (int s = 0; s < NUM_STATES; s++) path[s] <= '0;
            fill       <= '0;
            best_state <= '0;
            out_valid  <= 1'b0;
            out_bit    <= 1'b0;
        end else if (in_valid) begin
            for (int s = 0; s < NUM_STATES; s++) path[s] <= path_nxt[s];
            fill       <= fill_nxt;
            best_state <= best_nxt;
            out_valid  <= (fill_nxt == CNT_W'(TB_DEPTH));
            out_bit    <= (fill_nxt == CNT_W'(TB_DEPTH)) ? path_nxt[best_nxt][TB_DEPTH-1] : 1'b0;
        end else begin
            out_valid  <= 1'b0;
            out_bit    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_smu_regex.sv
// Scoreboard bench for smu_regex: stimulus pushes expected outputs, a negedge monitor pops them.
module tb_smu_regex;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic [7:0] dec;
    logic [2:0] pm0, pm1, pm2, pm3, pm4, pm5, pm6, pm7;
    logic       out_valid;
    logic       out_bit;
    logic [2:0] best_state;

    int         vectors     = 0;
    int         miscompares = 0;
    int         frame_steps = 0;
    logic [3:0] sb [$];
    logic [3:0] exp_entry;
    logic [19:0] pat;
    logic [23:0] pmv;

    smu_regex #(.TB_DEPTH(16), .PM_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .dec        (dec),
        .pm0        (pm0),
        .pm1        (pm1),
        .pm2        (pm2),
        .pm3        (pm3),
        .pm4        (pm4),
        .pm5        (pm5),
        .pm6        (pm6),
        .pm7        (pm7),
        .out_valid  (out_valid),
        .out_bit    (out_bit),
        .best_state (best_state)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One metric set with state s at value v and every other state at o.
    function automatic logic [23:0] pm_with(input int s, input logic [2:0] v, input logic [2:0] o);
        logic [23:0] r;
        for (int i = 0; i < 8; i++) r[3*i +: 3] = (i == s) ? v : o;
        return r;
    endfunction

    task automatic apply_stimulus(input logic [7:0] d, input logic [23:0] p,
                                  input logic exp_bit, input logic [2:0] exp_best);
        dec = d;
        {pm7, pm6, pm5, pm4, pm3, pm2, pm1, pm0} = p;
        clr      = 1'b0;
        in_valid = 1'b1;
        if (frame_steps < 16) frame_steps++;
        if (frame_steps == 16) sb.push_back({exp_bit, exp_best});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        frame_steps = 0;
    endtask

    task automatic drain_check(input string name);
        repeat (2) @(posedge clk);
        #1;
        check_output(name, sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_out: got out_valid 1, expected 0 at %0t", $time);
                end else begin
                    exp_entry = sb.pop_front();
                    check_output("out_bit", out_bit, exp_entry[3]);
                    check_output("best_state_out", best_state, exp_entry[2:0]);
                end
            end else begin
                check_output("idle_out_bit", out_bit, 0);
            end
        end
    end

    initial begin
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; dec = '0;
        {pm7, pm6, pm5, pm4, pm3, pm2, pm1, pm0} = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_out_bit", out_bit, 0);
        check_output("reset_best_state", best_state, 0);
        rst = 1'b1;
        frame_steps = 0;

        $display("[TB] all-zero decisions, state 0 best");
        for (int k = 1; k <= 20; k++) begin
            apply_stimulus(8'h00, pm_with(0, 3'd0, 3'd7), 1'b0, 3'd0);
            if (k == 15) check_output("no_out_before_fill", out_valid, 0);
            if (k == 16) check_output("first_out_valid", out_valid, 1);
        end
        drain_check("drain_zero_run");

        $display("[TB] all-one decisions, state 7 best");
        do_clr();
        check_output("clr_out_valid", out_valid, 0);
        check_output("clr_best_state", best_state, 0);
        for (int k = 1; k <= 20; k++) apply_stimulus(8'hFF, pm_with(7, 3'd0, 3'd5), 1'b1, 3'd7);
        drain_check("drain_one_run");

        $display("[TB] argmin tie and boundary cases");
        do_clr();
        apply_stimulus(8'h00, {8{3'd3}}, 1'b0, 3'd0);
        check_output("tie_all_equal", best_state, 0);
        pmv = pm_with(2, 3'd1, 3'd4);
        pmv[18 +: 3] = 3'd1;
        apply_stimulus(8'h00, pmv, 1'b0, 3'd0);
        check_output("tie_pm2_pm6", best_state, 2);
        apply_stimulus(8'h00, pm_with(5, 3'd6, 3'd7), 1'b0, 3'd0);
        check_output("min_near_max", best_state, 5);
        apply_stimulus(8'h00, pm_with(7, 3'd0, 3'd7), 1'b0, 3'd0);
        check_output("min_last_state", best_state, 7);
        apply_stimulus(8'h00, {8{3'd7}}, 1'b0, 3'd0);
        check_output("tie_all_max", best_state, 0);

        // With uniform per-step decisions the emitted bit is the decision 12 steps back.
        pat = 20'hC3A5D;
        $display("[TB] patterned decisions, gapless");
        do_clr();
        for (int k = 1; k <= 20; k++)
            apply_stimulus(pat[k-1] ? 8'hFF : 8'h00, pm_with(0, 3'd0, 3'd7),
                           (k >= 16) ? pat[k-13] : 1'b0, 3'd0);
        drain_check("drain_pattern");

        $display("[TB] patterned decisions, gap after step 10");
        do_clr();
        for (int k = 1; k <= 20; k++) begin
            apply_stimulus(pat[k-1] ? 8'hFF : 8'h00, pm_with(0, 3'd0, 3'd7),
                           (k >= 16) ? pat[k-13] : 1'b0, 3'd0);
            if (k == 10) begin
                for (int g = 0; g < 3; g++) begin
                    @(posedge clk);
                    #1;
                    check_output("gap_best_hold", best_state, 0);
                    check_output("gap_no_out", out_valid, 0);
                end
            end
        end
        drain_check("drain_gap");

        $display("[TB] clr colliding with a step");
        do_clr();
        for (int k = 1; k <= 11; k++) apply_stimulus(8'hFF, pm_with(7, 3'd0, 3'd5), 1'b1, 3'd7);
        dec = 8'hFF; clr = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; in_valid = 1'b0; frame_steps = 0;
        check_output("collide_best_zero", best_state, 0);
        check_output("collide_no_out", out_valid, 0);
        for (int k = 1; k <= 16; k++) begin
            apply_stimulus(8'hFF, pm_with(7, 3'd0, 3'd5), 1'b1, 3'd7);
            if (k == 15) check_output("collide_no_early_out", out_valid, 0);
            if (k == 16) check_output("collide_out_after_16", out_valid, 1);
        end
        drain_check("drain_collide");

        $display("[TB] reset pulse mid-frame");
        do_clr();
        for (int k = 1; k <= 17; k++) apply_stimulus(8'hFF, pm_with(7, 3'd0, 3'd5), 1'b1, 3'd7);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("async_rst_out_valid", out_valid, 0);
        check_output("async_rst_out_bit", out_bit, 0);
        check_output("async_rst_best", best_state, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        frame_steps = 0;
        for (int k = 1; k <= 16; k++) begin
            apply_stimulus(8'hFF, pm_with(7, 3'd0, 3'd5), 1'b1, 3'd7);
            if (k == 15) check_output("rst_no_early_out", out_valid, 0);
            if (k == 16) check_output("rst_out_after_16", out_valid, 1);
        end
        drain_check("drain_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
